// File: rtl/delay_pkg.sv
// Shared constants and helpers for the delay_line family.
package delay_pkg;

  localparam int unsigned MAX_DEPTH = 64;

  // Tap bus width: one WIDTH slice per stage, or just din when there are no stages.
  function automatic int unsigned taps_width(input int unsigned depth, input int unsigned width);
    return ((depth > 32'd0) ? depth : 32'd1) * width;
  endfunction

endpackage

// File: rtl/delay_stage.sv
// One WIDTH-bit pipeline register with asynchronous active-low reset to RESET_VALUE.
module delay_stage #(
  parameter int unsigned      WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= RESET_VALUE;
    end else begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/delay_line.sv
// DEPTH-stage shift-register delay with full tap history and per-bit rise/fall
// detection of din against the delayed output.
module delay_line
  import delay_pkg::*;
#(
  parameter int unsigned      WIDTH       = 1,
  parameter int unsigned      DEPTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [WIDTH-1:0]                    din,
  output logic [WIDTH-1:0]                    dout,
  output logic [taps_width(DEPTH, WIDTH)-1:0] taps,
  output logic [WIDTH-1:0]                    rise,
  output logic [WIDTH-1:0]                    fall
);

  if (WIDTH == 0) begin : g_bad_width
    $error("delay_line: WIDTH must be at least 1");
  end

  if (DEPTH > MAX_DEPTH) begin : g_bad_depth
    $error("delay_line: DEPTH must be in 0..64");
  end

  if (DEPTH == 0) begin : g_passthru
    // No storage: clock and reset are intentionally left unused.
    logic w_unused;
    assign w_unused = &{1'b0, clk, reset};
    assign dout     = din;
    assign taps     = din;
  end else begin : g_pipe
    logic [WIDTH-1:0] w_stage [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic [WIDTH-1:0] w_d;

      if (i == 0) begin : g_head
        assign w_d = din;
      end else begin : g_link
        assign w_d = w_stage[i-1];
      end

      delay_stage #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
      ) u_stage (
        .clk   (clk),
        .rst_n (reset),
        .i_d   (w_d),
        .o_q   (w_stage[i])
      );

      assign taps[i*WIDTH +: WIDTH] = w_stage[i];
    end

    assign dout = w_stage[DEPTH-1];
  end

  // Edge pulses compare the live input with its delayed copy.
  assign rise = din & ~dout;
  assign fall = ~din & dout;

endmodule

// File: tb/tb_delay_line.sv
// Self-checking bench for delay_line: four parameterisations against a queue-based history model.
module tb_delay_line;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  logic        din1, dout1, taps1, rise1, fall1;
  logic [7:0]  din8, dout8, rise8, fall8;
  logic [31:0] taps8;
  logic [7:0]  dina, douta, risea, falla;
  logic [23:0] tapsa;
  logic [3:0]  din0, dout0, taps0, rise0, fall0;

  delay_line #(.WIDTH(1), .DEPTH(1)) u_d1 (
    .clk(clk), .reset(rst_n), .din(din1), .dout(dout1), .taps(taps1), .rise(rise1), .fall(fall1));
  delay_line #(.WIDTH(8), .DEPTH(4)) u_d8 (
    .clk(clk), .reset(rst_n), .din(din8), .dout(dout8), .taps(taps8), .rise(rise8), .fall(fall8));
  delay_line #(.WIDTH(8), .DEPTH(3), .RESET_VALUE(8'hA5)) u_da (
    .clk(clk), .reset(rst_n), .din(dina), .dout(douta), .taps(tapsa), .rise(risea), .fall(falla));
  delay_line #(.WIDTH(4), .DEPTH(0)) u_d0 (
    .clk(clk), .reset(rst_n), .din(din0), .dout(dout0), .taps(taps0), .rise(rise0), .fall(fall0));

  int tests = 0;
  int fails = 0;
  int rise_cnt = 0;
  int fall_cnt = 0;

  // Model: history of captured inputs, newest at index 0.
  logic       q1[$];
  logic [7:0] q8[$];
  logic [7:0] qa[$];

  task automatic model_reset();
    q1.delete(); q8.delete(); qa.delete();
    q1.push_back(1'b0);
    repeat (4) q8.push_back(8'h00);
    repeat (3) qa.push_back(8'hA5);
  endtask

  task automatic model_capture();
    q1.push_front(din1); void'(q1.pop_back());
    q8.push_front(din8); void'(q8.pop_back());
    qa.push_front(dina); void'(qa.pop_back());
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic        e1, er1, ef1;
    logic [7:0]  e8, er8, ef8, ea, era, efa;
    logic [31:0] et8;
    logic [23:0] eta;
    logic [3:0]  z4;
    e1  = q1[0];
    er1 = din1 & ~e1;
    ef1 = ~din1 & e1;
    e8  = q8[3];
    et8 = {q8[3], q8[2], q8[1], q8[0]};
    er8 = din8 & ~e8;
    ef8 = ~din8 & e8;
    ea  = qa[2];
    eta = {qa[2], qa[1], qa[0]};
    era = dina & ~ea;
    efa = ~dina & ea;
    z4  = 4'h0;
    chk("d1_dout", 32'(dout1), 32'(e1));
    chk("d1_taps", 32'(taps1), 32'(e1));
    chk("d1_rise", 32'(rise1), 32'(er1));
    chk("d1_fall", 32'(fall1), 32'(ef1));
    chk("d8_dout", 32'(dout8), 32'(e8));
    chk("d8_taps", taps8, et8);
    chk("d8_rise", 32'(rise8), 32'(er8));
    chk("d8_fall", 32'(fall8), 32'(ef8));
    chk("da_dout", 32'(douta), 32'(ea));
    chk("da_taps", 32'(tapsa), 32'(eta));
    chk("da_rise", 32'(risea), 32'(era));
    chk("da_fall", 32'(falla), 32'(efa));
    chk("d0_dout", 32'(dout0), 32'(din0));
    chk("d0_taps", 32'(taps0), 32'(din0));
    chk("d0_rise", 32'(rise0), 32'(z4));
    chk("d0_fall", 32'(fall0), 32'(z4));
    rise_cnt += int'(rise1);
    fall_cnt += int'(fall1);
  endtask

  // Apply inputs just after an edge, check mid-cycle, then take the next edge.
  task automatic cycle(input logic d1, input logic [7:0] d8, input logic [7:0] da, input logic [3:0] d0);
    din1 = d1; din8 = d8; dina = da; din0 = d0;
    #2;
    check_all();
    @(posedge clk);
    if (rst_n) model_capture();
    #1;
  endtask

  task automatic rnd_cycle();
    cycle(1'($urandom), 8'($urandom), 8'($urandom), 4'($urandom));
  endtask

  initial begin
    din1 = 1'b1; din8 = 8'h00; dina = 8'h00; din0 = 4'h0;
    model_reset();
    #1 rst_n = 1'b0;

    // Reset held for three cycles; din1=1 against a zero history must raise rise1.
    repeat (3) cycle(1'b1, 8'($urandom), 8'($urandom), 4'($urandom));

    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;

    // Directed 0,1,1,0 on the 1-bit line and a counting pattern on the 8-bit line.
    cycle(1'b0, 8'h01, 8'h11, 4'h1);
    cycle(1'b1, 8'h02, 8'h12, 4'h2);
    cycle(1'b1, 8'h03, 8'h13, 4'h3);
    cycle(1'b0, 8'h04, 8'h14, 4'h4);
    for (int i = 5; i <= 10; i++) cycle(1'($urandom), 8'(i), 8'($urandom), 4'($urandom));

    // Pass-through instance follows a mid-cycle change without any edge.
    din0 = 4'h3;
    #1 check_all();
    din0 = 4'hC;
    #1 check_all();
    @(posedge clk);
    model_capture();
    #1;

    repeat (30) rnd_cycle();

    // Reset pulled low between edges: history collapses to reset values at once.
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("da_async_taps", 32'(tapsa), 32'h00A5A5A5);
    @(posedge clk);
    #1;
    repeat (2) rnd_cycle();
    rst_n = 1'b1;
    repeat (3) begin
      chk("da_refill_hold", 32'(douta), 32'h000000A5);
      rnd_cycle();
    end
    repeat (4) rnd_cycle();

    // Slave-select pattern: steady high, low for 16 cycles, high again.
    repeat (2) cycle(1'b1, 8'($urandom), 8'($urandom), 4'($urandom));
    rise_cnt = 0;
    fall_cnt = 0;
    repeat (2) cycle(1'b1, 8'($urandom), 8'($urandom), 4'($urandom));
    chk("ss_no_pulse_steady", 32'(rise_cnt + fall_cnt), 32'd0);
    repeat (16) cycle(1'b0, 8'($urandom), 8'($urandom), 4'($urandom));
    chk("ss_fall_once", 32'(fall_cnt), 32'd1);
    chk("ss_no_rise_low", 32'(rise_cnt), 32'd0);
    repeat (4) cycle(1'b1, 8'($urandom), 8'($urandom), 4'($urandom));
    chk("ss_rise_once", 32'(rise_cnt), 32'd1);
    chk("ss_fall_total", 32'(fall_cnt), 32'd1);

    repeat (20) rnd_cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/delay_line.md
Name: delay_line

Overview:
- Parameterised synchronous shift-register delay: each input bit-vector appears at the output exactly DEPTH clock cycles later.
- Also provides the full tap history plus per-bit rise/fall pulses (input vs delayed output).
- Used across the design for one-cycle "last value" registers and edge detection on control strobes, e.g. SPI slave-select: rise = ss && !ss_last.
- The first four ports are positional-compatible with existing instantiations: clk, reset, din, dout.

Parameters:
- WIDTH, 1: bit width of din/dout.
- DEPTH, 1: number of register stages, legal range 0..64; 0 means combinational pass-through.
- RESET_VALUE, {WIDTH{1'b0}}: value loaded into every stage while reset is asserted.

Ports:
- clk  input  1  single clock; all stages update on its rising edge.
- reset  input  1  asynchronous, active-low reset; clears all stages to RESET_VALUE.
- din  input  WIDTH  signal to be delayed.
- dout  output  WIDTH  din delayed by DEPTH cycles; equals stage[DEPTH-1].
- taps  output  WIDTH*max(DEPTH,1)  concatenated stages; stage[0] (newest) in LSBs, stage[DEPTH-1] (oldest) in MSBs. When DEPTH=0, taps = din.
- rise  output  WIDTH  combinational, per bit: din & ~dout.
- fall  output  WIDTH  combinational, per bit: ~din & dout.

Behaviour:
- Async reset. When reset falls to 0, every stage takes RESET_VALUE immediately, with no clock needed. Stages hold while reset = 0. The first capture occurs on the first rising clk edge after reset returns to 1.
- Reset is asserted-asynchronous. Deassertion synchronisation is the integrator's responsibility; this block does no internal synchroniser.
- Every rising clk edge with reset = 1:
  - stage[0] <= din;
  - stage[i] <= stage[i-1] for 1 <= i < DEPTH.
- Latency:
  - A value present on din at edge n appears on dout after edge n+DEPTH-1 completes, i.e. it is visible during cycle n+DEPTH.
  - DEPTH=1 gives dout(t) = din(t-1).
- DEPTH=0: no registers; dout = din, taps = din; reset has no effect; rise and fall are constant 0.
- Reset values of outputs:
  - dout = RESET_VALUE; taps = all stages RESET_VALUE.
  - rise/fall follow din combinationally against RESET_VALUE. Example: din=1, RESET_VALUE=0 during reset gives rise=1.
- No enable or stall: the shift occurs on every edge. No X propagation out of reset. No internal state other than the stages.
- Reset asserted mid-operation: all in-flight history is discarded. After release the pipeline refills from scratch, and dout shows RESET_VALUE for DEPTH cycles.
- Simultaneous din change and clock edge: the standard setup-time sample applies, with no special handling.
- Widths: WIDTH >= 1 is enforced by an elaboration-time check. DEPTH outside 0..64 fails elaboration.

Decomposition:
- Shared package (delay_pkg): MAX_DEPTH = 64 constant and a function computing taps width, max(DEPTH,1)*WIDTH.
- Sub-module delay_stage: one WIDTH-bit async-reset register with RESET_VALUE. delay_line generates DEPTH instances chained together, with a generate branch for DEPTH=0.
- Edge logic (rise/fall) is inline in delay_line.

Test Plan:
- WIDTH=1, DEPTH=1, reset held low 3 cycles then released; din sequence 0,1,1,0.
  - dout is 0 during reset, then 0,0,1,1,0 (one cycle late).
  - rise=1 only in the cycle din=1 and dout=0; fall=1 only in the cycle din=0 and dout=1.
- WIDTH=8, DEPTH=4, din = 8'h01,02,03,... one per cycle.
  - dout = 8'h00 for the first 4 cycles after reset, then 01,02,03 in order.
  - taps = {stage3,stage2,stage1,stage0} matches the last four inputs each cycle.
- WIDTH=8, DEPTH=3, RESET_VALUE=8'hA5: run data, then pull reset low between clock edges.
  - dout and all taps become A5 immediately, with no edge required.
  - After release, A5 is held for 3 cycles before new data emerges.
- DEPTH=0, WIDTH=4: toggle din 4'h3 -> 4'hC mid-cycle.
  - dout and taps follow in the same delta.
  - rise = fall = 4'h0; reset has no effect.
- WIDTH=1, DEPTH=1 slave-select pattern: ss high, low for 16 cycles, high.
  - rise pulses for exactly one cycle on ss 0->1.
  - fall pulses for exactly one cycle on ss 1->0.
  - No pulse while ss is steady.
